// File: rtl/bram_uart_dump.sv
// bram_uart_dump: streams a run of bytes out of the 8-bit block RAM onto a
// UART TX line (8N1, LSB first). The stop bit of each frame is also used to
// prefetch the next byte, so consecutive frames leave no idle gap on the line.
module bram_uart_dump #(
  parameter int WIDTH        = 8,
  parameter int LEN          = 2048,
  parameter int CLKS_PER_BIT = 234,
  parameter int ADDR_W       = $clog2(LEN) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic [WIDTH-1:0]  mem_dout,
  output logic              tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_FIN
  } state_t;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_cnt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] ptr_inc;
  logic [ADDR_W-1:0] base_mod;
  logic [WIDTH-1:0]  shift;
  logic              bit_end;

  // Last clock of the current bit period.
  assign bit_end  = (baud == BAUD_W'(CLKS_PER_BIT - 1));
  // Next RAM address, wrapping at the end of the array.
  assign ptr_inc  = (ptr == ADDR_W'(LEN - 1)) ? '0 : ptr + ADDR_W'(1);
  // An out-of-range base address folds back into the array.
  assign base_mod = ADDR_W'(base_addr % ADDR_W'(LEN));

  // The RAM is only ever read from this end; a job spans IDLE-exit to FIN.
  assign mem_we = 1'b0;
  assign busy   = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: every clocked assignment is non-blocking so all registers
      // update from the same pre-edge values, regardless of statement order.
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first, so no path through the case leaves state_nxt
    // unassigned and no latch is inferred.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = (count == '0) ? S_FIN : S_FETCH;
      S_FETCH: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_START;
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA:  if (bit_end && bit_cnt == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (bit_end) state_nxt = (remaining != '0) ? S_START : S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: address pointer, byte counter, baud/bit timing and the TX shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: tx sits on the async reset so the line returns to idle-high
      // the moment reset asserts, even mid-frame.
      tx        <= 1'b1;
      done      <= 1'b0;
      mem_addr  <= '0;
      ptr       <= '0;
      remaining <= '0;
      shift     <= '0;
      baud      <= '0;
      bit_cnt   <= '0;
    end else begin
      done <= (state == S_FIN);
      unique case (state)
        S_IDLE: begin
          if (start && count != '0) begin
            ptr       <= base_mod;
            remaining <= count;
            mem_addr  <= base_mod;
          end
        end
        S_LOAD: begin
          shift     <= mem_dout;
          tx        <= 1'b0;
          baud      <= '0;
          bit_cnt   <= '0;
          remaining <= remaining - ADDR_W'(1);
        end
        S_START: begin
          if (bit_end) begin
            baud <= '0;
            tx   <= shift[0];
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_cnt == 3'd7) begin
              tx <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        S_STOP: begin
          // Prefetch on the first stop-bit clock; the read has the rest of
          // the stop bit to settle.
          if (baud == '0 && remaining != '0) begin
            ptr      <= ptr_inc;
            mem_addr <= ptr_inc;
          end
          if (bit_end) begin
            baud <= '0;
            if (remaining != '0) begin
              // Same action as LOAD, folded into the stop-bit end.
              shift     <= mem_dout;
              tx        <= 1'b0;
              bit_cnt   <= '0;
              remaining <= remaining - ADDR_W'(1);
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_uart_dump.sv
// Bench for bram_uart_dump: small RAM (LEN=16) and fast UART (4 clocks/bit).
// Each job's tx waveform, busy/done timing, RAM address sequence and decoded
// bytes are compared with values derived from the RAM contents and UART rules.
module tb_bram_uart_dump;

  localparam int LEN = 16;
  localparam int CPB = 4;
  localparam int AW  = $clog2(LEN) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] count = '0;
  logic          busy, done, mem_we, tx;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_dout;

  logic [7:0] ram [LEN];
  int total = 0;
  int bad = 0;

  logic [7:0] dec_q[$];
  int         addr_q[$];

  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears one clock after the address.
  always @(posedge clk) mem_dout <= ram[int'(mem_addr) % LEN];

  bram_uart_dump #(
    .WIDTH(8),
    .LEN(LEN),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .count(count),
    .busy(busy),
    .done(done),
    .mem_addr(mem_addr),
    .mem_we(mem_we),
    .mem_dout(mem_dout),
    .tx(tx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Runs one job with count != 0. Sample j is taken at the falling edge
  // after the j-th rising edge following the one that accepts start.
  // Expected: tx low from j=2 for 10*cnt*CPB samples, done at j=frame+3.
  // With poke set, an extra start is pulsed mid-job and must be ignored.
  task automatic run_job(input int base, input int cnt, input bit poke);
    int         frame;
    int         n_samp;
    int         b0;
    logic [7:0] exp_b[$];
    logic       tx_s[$];
    logic [7:0] v;
    logic       e;
    int wave_bad, busy_bad, done_bad, addr_bad, byte_bad, stop_bad;
    int first_fall, we_seen, idx, off, nb, bp;
    frame  = 10 * cnt * CPB;
    n_samp = frame + 5;
    b0     = base % LEN;
    wave_bad = 0; busy_bad = 0; done_bad = 0; addr_bad = 0;
    byte_bad = 0; stop_bad = 0; first_fall = -1; we_seen = 0;
    for (int i = 0; i < cnt; i++) exp_b.push_back(ram[(b0 + i) % LEN]);
    dec_q.delete();
    addr_q.delete();

    @(negedge clk);
    start = 1'b1; base_addr = AW'(base); count = AW'(cnt);
    for (int j = 0; j < n_samp; j++) begin
      @(negedge clk);
      tx_s.push_back(tx);
      if (mem_we !== 1'b0) we_seen = 1;
      if (j == 0 || int'(mem_addr) != addr_q[$]) addr_q.push_back(int'(mem_addr));
      if (busy !== (j <= frame + 2)) busy_bad++;
      if (done !== (j == frame + 3)) done_bad++;
      if (j < 2 || j >= frame + 2) begin
        e = 1'b1;
      end else begin
        off = j - 2;
        nb  = off / (10 * CPB);
        bp  = (off % (10 * CPB)) / CPB;
        e   = (bp == 0) ? 1'b0 : (bp == 9) ? 1'b1 : exp_b[nb][bp-1];
      end
      if (tx !== e) wave_bad++;
      if (first_fall < 0 && tx === 1'b0) first_fall = j;
      if (j == 0) start = 1'b0;
      if (poke && j == frame / 2) begin
        start = 1'b1; base_addr = AW'(base + 3); count = '0;
      end
      if (poke && j == frame / 2 + 1) start = 1'b0;
    end
    start = 1'b0;

    // UART receiver: find a falling edge, sample each bit mid-period.
    idx = 0;
    while (idx < tx_s.size()) begin
      if (tx_s[idx] === 1'b0 && idx + 10 * CPB <= tx_s.size()) begin
        for (int b = 0; b < 8; b++) v[b] = tx_s[idx + CPB / 2 + (b + 1) * CPB];
        dec_q.push_back(v);
        idx += 9 * CPB + CPB / 2;
        if (tx_s[idx] !== 1'b1) stop_bad++;
      end else begin
        idx++;
      end
    end

    for (int i = 0; i < cnt; i++) begin
      if (i >= dec_q.size() || dec_q[i] !== exp_b[i]) byte_bad++;
      if (i >= addr_q.size() || addr_q[i] != (b0 + i) % LEN) addr_bad++;
    end

    check("first_fall", first_fall, 2);
    check("tx_wave", wave_bad, 0);
    check("busy", busy_bad, 0);
    check("done", done_bad, 0);
    check("mem_we", we_seen, 0);
    check("stop_bits", stop_bad, 0);
    check("nbytes", dec_q.size(), cnt);
    check("bytes", byte_bad, 0);
    check("naddr", addr_q.size(), cnt);
    check("addr_seq", addr_bad, 0);
  endtask

  // count=0: busy for one cycle, done the cycle after, tx untouched.
  task automatic zero_job();
    @(negedge clk);
    start = 1'b1; base_addr = AW'(9); count = '0;
    @(negedge clk);
    start = 1'b0;
    check("z_busy0", busy, 1);
    check("z_done0", done, 0);
    check("z_tx0", tx, 1);
    @(negedge clk);
    check("z_busy1", busy, 0);
    check("z_done1", done, 1);
    check("z_tx1", tx, 1);
    @(negedge clk);
    check("z_done2", done, 0);
    check("z_tx2", tx, 1);
  endtask

  initial begin
    for (int a = 0; a < LEN; a++) ram[a] = 8'($urandom);
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_we", mem_we, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5 at address 5.
    ram[5] = 8'hA5;
    run_job(5, 1, 1'b0);
    check("single_byte", dec_q.size() > 0 ? dec_q[0] : 8'h00, 8'hA5);

    // Back-to-back frames.
    ram[0] = 8'h00; ram[1] = 8'hFF; ram[2] = 8'h55; ram[3] = 8'h81;
    run_job(0, 4, 1'b0);
    check("b2b_0", dec_q.size() > 0 ? dec_q[0] : 8'h5A, 8'h00);
    check("b2b_1", dec_q.size() > 1 ? dec_q[1] : 8'h5A, 8'hFF);
    check("b2b_2", dec_q.size() > 2 ? dec_q[2] : 8'h5A, 8'h55);
    check("b2b_3", dec_q.size() > 3 ? dec_q[3] : 8'h5A, 8'h81);

    // Address wrap at the end of the array.
    ram[14] = 8'h11; ram[15] = 8'h22; ram[0] = 8'h33;
    run_job(14, 3, 1'b0);
    check("wrap_a0", addr_q.size() > 0 ? addr_q[0] : -1, 14);
    check("wrap_a1", addr_q.size() > 1 ? addr_q[1] : -1, 15);
    check("wrap_a2", addr_q.size() > 2 ? addr_q[2] : -1, 0);
    check("wrap_b0", dec_q.size() > 0 ? dec_q[0] : 8'h00, 8'h11);
    check("wrap_b1", dec_q.size() > 1 ? dec_q[1] : 8'h00, 8'h22);
    check("wrap_b2", dec_q.size() > 2 ? dec_q[2] : 8'h00, 8'h33);

    // Zero count, ignored mid-job start, base folding, count beyond LEN.
    zero_job();
    run_job(2, 3, 1'b1);
    run_job(20, 2, 1'b0);
    run_job(9, 20, 1'b0);

    // Reset during the data bits of the second of four bytes.
    ram[0] = 8'hFF; ram[1] = 8'h00; ram[2] = 8'hFF; ram[3] = 8'hFF;
    @(negedge clk);
    start = 1'b1; base_addr = '0; count = AW'(4);
    @(negedge clk);
    start = 1'b0;
    repeat (2 + 13 * CPB) @(negedge clk);
    check("pre_rst_tx", tx, 0);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_addr", mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", done, 0);
    ram[7] = 8'h3C;
    run_job(7, 1, 1'b0);
    check("post_rst_byte", dec_q.size() > 0 ? dec_q[0] : 8'h00, 8'h3C);

    // Random jobs with fresh RAM contents each time.
    for (int t = 0; t < 200; t++) begin
      for (int a = 0; a < LEN; a++) ram[a] = 8'($urandom);
      run_job(int'($urandom_range(0, (1 << AW) - 1)), int'($urandom_range(1, 10)), (t % 16) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
